// File: rtl/local_store_pkg.sv
// Shared encodings for the local store command bus: opcodes, sequencer FSM states
// and offset-kind indices, used by the sequencer and the PE-side store controllers.
package local_store_pkg;

    localparam logic [2:0] OP_INIT      = 3'b000;
    localparam logic [2:0] OP_HOLD      = 3'b001;
    localparam logic [2:0] OP_INCR      = 3'b010;
    localparam logic [2:0] OP_JUMP      = 3'b011;
    localparam logic [2:0] OP_SET_K_ROW = 3'b100;
    localparam logic [2:0] OP_SET_K_COL = 3'b101;
    localparam logic [2:0] OP_SET_N_ROW = 3'b110;
    localparam logic [2:0] OP_SET_N_COL = 3'b111;

    localparam int KIND_KROW = 0;
    localparam int KIND_KCOL = 1;
    localparam int KIND_NROW = 2;
    localparam int KIND_NCOL = 3;
    localparam int NUM_KINDS = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_INIT,
        ST_RUN,
        ST_JUMP,
        ST_DONE
    } seq_state_t;

    function automatic logic [5:0] cmd_pair(input logic [2:0] kernel_op, input logic [2:0] neuron_op);
        return {kernel_op, neuron_op};
    endfunction

endpackage

// File: rtl/local_store_sequencer_if.sv
// Job request inputs and store command bus outputs of the local store sequencer.
interface local_store_sequencer_if #(
    parameter int depth = 2,
    parameter int A     = 7,
    parameter int NPE   = 4
);
    logic                     start;
    logic                     setupEn;
    logic                     stall;
    logic [A-1:0]             rows;
    logic [A-1:0]             cols;
    logic [NPE*4*depth-1:0]   peOffsets;
    logic [5:0]               controlSignal;
    logic [NPE-1:0]           initPESelect;
    logic [depth-1:0]         initSettings;
    logic                     busy;
    logic                     done;

    modport master (
        output start, setupEn, stall, rows, cols, peOffsets,
        input  controlSignal, initPESelect, initSettings, busy, done
    );

    modport slave (
        input  start, setupEn, stall, rows, cols, peOffsets,
        output controlSignal, initPESelect, initSettings, busy, done
    );

endinterface

// File: rtl/pe_offset_loader.sv
// Walks (pe, kind) over 4*NPE cycles while go is high, emitting one SET command per step.
// Stall holds the walker and forces HOLD/zero outputs; last flags the final step.
module pe_offset_loader
    import local_store_pkg::*;
#(
    parameter int depth = 2,
    parameter int NPE   = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   go,
    input  logic                   stall,
    input  logic [NPE*4*depth-1:0] offsets,
    output logic                   last,
    output logic [2:0]             kernel_cmd,
    output logic [2:0]             neuron_cmd,
    output logic [NPE-1:0]         pe_select,
    output logic [depth-1:0]       settings
);

    localparam int NSTEP = NUM_KINDS * NPE;
    localparam int IW    = $clog2(NSTEP);

    // Step index is (4*pe + kind), which is also the offset slot index.
    logic [IW-1:0] idx;
    logic [1:0]    kind;
    logic [IW-1:0] pe;

    always_ff @(posedge CLK) begin
        if (RST || !go) begin
            idx <= '0;
        end else if (!stall) begin
            idx <= idx + IW'(1);
        end
    end

    assign last = (idx == IW'(NSTEP - 1));
    assign kind = idx[1:0];
    assign pe   = idx >> 2;

    always_comb begin
        kernel_cmd = OP_HOLD;
        neuron_cmd = OP_HOLD;
        pe_select  = '0;
        settings   = '0;
        if (go && !stall) begin
            pe_select = NPE'(1) << pe;
            settings  = offsets[int'(idx)*depth +: depth];
            case (int'(kind))
                KIND_KROW: kernel_cmd = OP_SET_K_ROW;
                KIND_KCOL: kernel_cmd = OP_SET_K_COL;
                KIND_NROW: neuron_cmd = OP_SET_N_ROW;
                default:   neuron_cmd = OP_SET_N_COL;
            endcase
        end
    end

endmodule

// File: rtl/local_store_sequencer.sv
// Command source for the PE local store controllers: optional offset setup, then a rows x cols walk.
// One command per cycle, first one the cycle after start; stall inserts HOLD and replays the command.
module local_store_sequencer
    import local_store_pkg::*;
#(
    parameter int depth = 2,
    parameter int A     = 7,
    parameter int NPE   = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    local_store_sequencer_if.slave  bus
);

    seq_state_t state, state_n;

    logic [A-1:0]           rows_q, cols_q, r, c;
    logic [A-1:0]           rows_m1, cols_m1;
    logic [NPE*4*depth-1:0] offs_q;
    logic                   zero_size, single_col;

    logic                   ld_last;
    logic [2:0]             ld_k, ld_n;
    logic [NPE-1:0]         ld_sel;
    logic [depth-1:0]       ld_set;

    logic [5:0]             cmd;
    logic [NPE-1:0]         sel_o;
    logic [depth-1:0]       set_o;
    logic                   done_o;

    assign zero_size  = (bus.rows == '0) || (bus.cols == '0);
    assign rows_m1    = rows_q - A'(1);
    assign cols_m1    = cols_q - A'(1);
    assign single_col = (cols_q == A'(1));

    pe_offset_loader #(.depth(depth), .NPE(NPE)) u_loader (
        .CLK        (CLK),
        .RST        (RST),
        .go         (state == ST_SETUP),
        .stall      (bus.stall),
        .offsets    (offs_q),
        .last       (ld_last),
        .kernel_cmd (ld_k),
        .neuron_cmd (ld_n),
        .pe_select  (ld_sel),
        .settings   (ld_set)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rows_q <= '0;
            cols_q <= '0;
            offs_q <= '0;
            r      <= '0;
            c      <= '0;
        end else begin
            if (state == ST_IDLE && bus.start) begin
                rows_q <= bus.rows;
                cols_q <= bus.cols;
                offs_q <= bus.peOffsets;
            end
            if (!bus.stall) begin
                case (state)
                    ST_INIT: begin
                        r <= '0;
                        c <= '0;
                    end
                    ST_RUN:  c <= c + A'(1);
                    ST_JUMP: begin
                        r <= r + A'(1);
                        c <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // With a single column a row has no INCR, so INIT/JUMP decide the row exit directly
    // using the row index that RUN would have seen.
    always_comb begin
        state_n = state;
        cmd     = cmd_pair(OP_HOLD, OP_HOLD);
        sel_o   = '0;
        set_o   = '0;
        done_o  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (zero_size)        state_n = ST_DONE;
                    else if (bus.setupEn) state_n = ST_SETUP;
                    else                  state_n = ST_INIT;
                end
            end
            ST_SETUP: begin
                cmd   = cmd_pair(ld_k, ld_n);
                sel_o = ld_sel;
                set_o = ld_set;
                if (!bus.stall && ld_last) state_n = ST_INIT;
            end
            ST_INIT: begin
                if (!bus.stall) begin
                    cmd = cmd_pair(OP_INIT, OP_INIT);
                    if (single_col) state_n = (rows_m1 == '0) ? ST_DONE : ST_JUMP;
                    else            state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.stall) begin
                    cmd = cmd_pair(OP_INCR, OP_INCR);
                    if (c + A'(1) == cols_m1) state_n = (r == rows_m1) ? ST_DONE : ST_JUMP;
                end
            end
            ST_JUMP: begin
                if (!bus.stall) begin
                    cmd = cmd_pair(OP_JUMP, OP_JUMP);
                    if (single_col) state_n = (r + A'(1) == rows_m1) ? ST_DONE : ST_JUMP;
                    else            state_n = ST_RUN;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.controlSignal = cmd;
    assign bus.initPESelect  = sel_o;
    assign bus.initSettings  = set_o;
    assign bus.busy          = (state != ST_IDLE);
    assign bus.done          = done_o;

endmodule

// File: tb/tb_local_store_sequencer.sv
// Directed bench for local_store_sequencer: drives on negedge, samples 1ns later.
module tb_local_store_sequencer;

    localparam int DEPTH = 2;
    localparam int AW    = 7;
    localparam int N     = 4;

    localparam logic [5:0] HH = 6'b001_001;
    localparam logic [5:0] II = 6'b000_000;
    localparam logic [5:0] NN = 6'b010_010;
    localparam logic [5:0] JJ = 6'b011_011;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    local_store_sequencer_if #(.depth(DEPTH), .A(AW), .NPE(N)) bus ();

    local_store_sequencer #(.depth(DEPTH), .A(AW), .NPE(N)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [5:0]       ctl;
    logic [N-1:0]     sel;
    logic [DEPTH-1:0] val;
    logic             bsy, dn;

    logic [5:0]       q_ctl[$];
    logic [N-1:0]     q_sel[$];
    logic [DEPTH-1:0] q_val[$];
    int               n_busy, n_done, done_at;

    task automatic tick(input logic st, input logic stl);
        @(negedge clk);
        bus.start = st;
        bus.stall = stl;
        #1;
        ctl = bus.controlSignal;
        sel = bus.initPESelect;
        val = bus.initSettings;
        bsy = bus.busy;
        dn  = bus.done;
    endtask

    // Cycle 0 is the start cycle; entries of q_* are cycles 1, 2, ...
    task automatic run_job(input logic [AW-1:0] r, input logic [AW-1:0] c, input logic su,
                           input logic [63:0] stall_m, input logic [63:0] start_m);
        bit seen;
        q_ctl.delete(); q_sel.delete(); q_val.delete();
        n_busy = 0; n_done = 0; done_at = -1; seen = 0;
        bus.rows = r; bus.cols = c; bus.setupEn = su;
        tick(1'b1, 1'b0);
        for (int i = 1; i < 200 && (!seen || i <= done_at + 3); i++) begin
            tick(i < 64 ? start_m[i] : 1'b0, i < 64 ? stall_m[i] : 1'b0);
            q_ctl.push_back(ctl);
            q_sel.push_back(sel);
            q_val.push_back(val);
            if (bsy) n_busy++;
            if (dn) begin
                n_done++;
                if (!seen) begin
                    seen = 1;
                    done_at = i;
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL job_timeout: no done pulse within 200 cycles (rows=%0d cols=%0d)", r, c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 0; bus.stall = 0; bus.setupEn = 0;
        bus.rows = '0; bus.cols = '0;
        tick(0, 0);
        tick(0, 0);
        rst = 1'b0;
        tick(0, 0);
        checks++;
        if (ctl !== HH) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, HH); end
        checks++;
        if ({sel, val} !== '0) begin errors++; $display("FAIL reset_sel_val: got %b/%b expected 0/0", sel, val); end
        checks++;
        if ({bsy, dn} !== 2'b00) begin errors++; $display("FAIL reset_busy_done: got %b expected 00", {bsy, dn}); end
    endtask

    task automatic test_basic_window();
        logic [5:0] exp[6] = '{II, NN, NN, JJ, NN, NN};
        bit side;
        run_job(2, 3, 0, 64'h0, 64'h0);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (q_ctl[i] !== exp[i]) begin
                errors++; $display("FAIL basic_seq[%0d]: got %b expected %b", i + 1, q_ctl[i], exp[i]);
            end
        end
        checks++;
        if (q_ctl[6] !== HH) begin errors++; $display("FAIL basic_done_bus: got %b expected %b", q_ctl[6], HH); end
        checks++;
        if (done_at !== 7) begin errors++; $display("FAIL basic_done_at: got %0d expected 7", done_at); end
        checks++;
        if (n_busy !== 7) begin errors++; $display("FAIL basic_busy_len: got %0d expected 7", n_busy); end
        side = 0;
        foreach (q_sel[i]) if (q_sel[i] !== '0 || q_val[i] !== '0) side = 1;
        checks++;
        if (side) begin errors++; $display("FAIL basic_sel_val: got nonzero select/value expected all 0"); end
    endtask

    task automatic test_setup();
        logic [5:0] kexp[4] = '{6'b100_001, 6'b101_001, 6'b001_110, 6'b001_111};
        logic [N-1:0]     es;
        logic [DEPTH-1:0] ev;
        logic [N*4*DEPTH-1:0] offs;
        for (int p = 0; p < N; p++)
            for (int k = 0; k < 4; k++)
                offs[(4*p+k)*DEPTH +: DEPTH] = DEPTH'((p + k + 3) % 4);
        bus.peOffsets = offs;
        run_job(2, 3, 1, 64'h0, 64'h0);
        for (int s = 0; s < 16; s++) begin
            es = N'(1) << (s / 4);
            ev = DEPTH'((s / 4 + s % 4 + 3) % 4);
            checks++;
            if (q_ctl[s] !== kexp[s % 4] || q_sel[s] !== es || q_val[s] !== ev) begin
                errors++;
                $display("FAIL setup_step[%0d]: got %b/%b/%0d expected %b/%b/%0d",
                         s, q_ctl[s], q_sel[s], q_val[s], kexp[s % 4], es, ev);
            end
        end
        checks++;
        if (q_sel[8] !== 4'b0100 || q_val[9] !== 2'd2 || q_val[10] !== 2'd3 || q_val[11] !== 2'd0) begin
            errors++; $display("FAIL setup_pe2: got sel %b vals %0d,%0d,%0d expected 0100 2,3,0",
                               q_sel[8], q_val[9], q_val[10], q_val[11]);
        end
        checks++;
        if (q_ctl[16] !== II || q_sel[16] !== '0) begin
            errors++; $display("FAIL setup_then_init: got %b/%b expected %b/0", q_ctl[16], q_sel[16], II);
        end
        checks++;
        if (done_at !== 23 || n_busy !== 23) begin
            errors++; $display("FAIL setup_len: got done@%0d busy %0d expected 23/23", done_at, n_busy);
        end
    endtask

    task automatic test_edges();
        logic [5:0] exp[3] = '{II, JJ, JJ};
        bit incr_seen;
        run_job(3, 1, 0, 64'h0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (q_ctl[i] !== exp[i]) begin
                errors++; $display("FAIL col1_seq[%0d]: got %b expected %b", i + 1, q_ctl[i], exp[i]);
            end
        end
        incr_seen = 0;
        foreach (q_ctl[i]) if (q_ctl[i] === NN) incr_seen = 1;
        checks++;
        if (incr_seen || done_at !== 4) begin
            errors++; $display("FAIL col1_len: got done@%0d incr=%0d expected done@4 incr=0", done_at, incr_seen);
        end
        run_job(0, 5, 1, 64'h0, 64'h0);
        checks++;
        if (done_at !== 1 || n_busy !== 1 || q_ctl[0] !== HH || q_sel[0] !== '0) begin
            errors++; $display("FAIL rows0: got done@%0d busy %0d bus %b sel %b expected 1/1/%b/0",
                               done_at, n_busy, q_ctl[0], q_sel[0], HH);
        end
        run_job(4, 0, 0, 64'h0, 64'h0);
        checks++;
        if (done_at !== 1 || q_ctl[0] !== HH) begin
            errors++; $display("FAIL cols0: got done@%0d bus %b expected 1/%b", done_at, q_ctl[0], HH);
        end
    endtask

    task automatic test_stall();
        logic [5:0] exp[8] = '{II, NN, HH, HH, NN, JJ, NN, NN};
        run_job(2, 3, 0, 64'h18, 64'h0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (q_ctl[i] !== exp[i]) begin
                errors++; $display("FAIL stall_seq[%0d]: got %b expected %b", i + 1, q_ctl[i], exp[i]);
            end
        end
        checks++;
        if (done_at !== 9 || n_busy !== 9) begin
            errors++; $display("FAIL stall_len: got done@%0d busy %0d expected 9/9", done_at, n_busy);
        end
    endtask

    task automatic test_reset_in_setup();
        bus.setupEn = 1; bus.rows = 2; bus.cols = 3;
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        tick(0, 0);
        rst = 1'b1;
        tick(0, 0);
        rst = 1'b0;
        checks++;
        if (ctl !== HH || sel !== '0 || val !== '0 || bsy !== 1'b0 || dn !== 1'b0) begin
            errors++; $display("FAIL rst_setup_idle: got %b/%b/%0d/%b/%b expected %b/0/0/0/0",
                               ctl, sel, val, bsy, dn, HH);
        end
        run_job(2, 3, 1, 64'h0, 64'h0);
        checks++;
        if (q_ctl[0] !== 6'b100_001 || q_sel[0] !== 4'b0001) begin
            errors++; $display("FAIL rst_restart_first: got %b/%b expected 100001/0001", q_ctl[0], q_sel[0]);
        end
        checks++;
        if (done_at !== 23 || n_done !== 1) begin
            errors++; $display("FAIL rst_restart_len: got done@%0d dones %0d expected 23/1", done_at, n_done);
        end
    endtask

    task automatic test_start_ignored();
        run_job(2, 3, 0, 64'h0, 64'h8C);
        checks++;
        if (n_done !== 1 || n_busy !== 7 || done_at !== 7) begin
            errors++; $display("FAIL start_ignored: got dones %0d busy %0d done@%0d expected 1/7/7",
                               n_done, n_busy, done_at);
        end
        checks++;
        if (q_ctl[3] !== JJ || q_ctl[5] !== NN) begin
            errors++; $display("FAIL start_ignored_seq: got %b,%b expected %b,%b", q_ctl[3], q_ctl[5], JJ, NN);
        end
    endtask

    initial begin
        bus.peOffsets = '0;
        test_reset();
        test_basic_window();
        test_setup();
        test_edges();
        test_stall();
        test_reset_in_setup();
        test_start_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
